// File: rtl/telemetry_framer.sv
// Periodic multi-channel telemetry packetiser: snapshots NUM_CH samples on each
// divider tick and issues SYNC, SEQ, payload (LSB first) and optional CHK bytes.
module telemetry_framer #(
    parameter int         NUM_CH      = 2,
    parameter int         DATA_W      = 16,
    parameter int         SAMPLE_DIV  = 16384,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         CHECKSUM_EN = 1
) (
    input  logic                     Clk,
    input  logic                     n_reset,
    input  logic                     i_enable,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic                     i_end,
    input  logic                     i_uart_full,
    output logic [7:0]               o_data,
    output logic                     o_wr,
    output logic                     o_busy,
    output logic                     o_overrun,
    output logic                     o_ended,
    output logic [15:0]              o_frame_cnt
);

    localparam int PAY_BYTES = NUM_CH * DATA_W / 8;
    localparam int IDX_W     = (PAY_BYTES > 1) ? $clog2(PAY_BYTES) : 1;
    localparam int DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_BYTES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_PAY,
        S_CHK
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [DIV_W-1:0]          r_div;
    logic [NUM_CH*DATA_W-1:0]  r_shadow;
    logic [IDX_W-1:0]          r_idx;
    logic [7:0]                r_sum;
    logic [7:0]                r_seq;
    logic                      r_is_end;
    logic                      r_overrun;
    logic                      r_ended;
    logic [15:0]               r_frame_cnt;

    logic                      w_tick;
    logic                      w_load;
    logic                      w_wr;
    logic                      w_done;
    logic [7:0]                w_byte;
    logic [7:0]                w_pay_bytes [PAY_BYTES];

    // Flattened channel k occupies bytes k*DATA_W/8.., so byte order is linear.
    for (genvar b = 0; b < PAY_BYTES; b++) begin : g_bytes
        assign w_pay_bytes[b] = r_shadow[b*8 +: 8];
    end

    assign w_tick = i_enable && (r_div == DIV_MAX);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge Clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        w_byte = 8'h00;
        w_wr   = 1'b0;
        w_load = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && !(i_end && r_ended)) begin
                    w_load = 1'b1;
                    w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                w_byte = SYNC_BYTE;
                if (!i_uart_full) begin
                    w_wr   = 1'b1;
                    w_next = S_SEQ;
                end
            end
            S_SEQ: begin
                w_byte = r_seq;
                if (!i_uart_full) begin
                    w_wr   = 1'b1;
                    w_next = S_PAY;
                end
            end
            S_PAY: begin
                w_byte = w_pay_bytes[r_idx];
                if (!i_uart_full) begin
                    w_wr = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        if (CHECKSUM_EN != 0) begin
                            w_next = S_CHK;
                        end else begin
                            w_next = S_IDLE;
                            w_done = 1'b1;
                        end
                    end
                end
            end
            S_CHK: begin
                w_byte = 8'h00 - r_sum;
                if (!i_uart_full) begin
                    w_wr   = 1'b1;
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div       <= '0;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_seq       <= '0;
            r_is_end    <= 1'b0;
            r_overrun   <= 1'b0;
            r_ended     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (!i_enable || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_load) begin
                r_shadow <= i_end ? '1 : i_data;
                r_is_end <= i_end;
                r_idx    <= '0;
                r_sum    <= '0;
            end

            if (w_wr && (r_state == S_SEQ || r_state == S_PAY)) begin
                r_sum <= r_sum + w_byte;
            end
            if (w_wr && r_state == S_PAY) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_done) begin
                r_seq       <= r_seq + 1'b1;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            // A tick that cannot start a frame is dropped and remembered.
            if (w_tick && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end

            if (w_done && r_is_end) begin
                r_ended <= 1'b1;
            end else if (!i_end) begin
                r_ended <= 1'b0;
            end
        end
    end

    assign o_data      = w_byte;
    assign o_wr        = w_wr;
    assign o_busy      = (r_state != S_IDLE);
    assign o_overrun   = r_overrun;
    assign o_ended     = r_ended;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: a 2x16-bit checksummed instance and a 3x8-bit
// instance without checksum, each with a byte scoreboard fed by the stimulus.
module tb_telemetry_framer;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  seq;
        logic [7:0]  chk;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        a_rst_n, a_en, a_end, a_full;
    logic [31:0] a_din;
    logic [7:0]  a_dout;
    logic        a_wr, a_busy, a_ovr, a_ended;
    logic [15:0] a_cnt;

    logic        b_rst_n, b_en, b_end, b_full;
    logic [23:0] b_din;
    logic [7:0]  b_dout;
    logic        b_wr, b_busy, b_ovr, b_ended;
    logic [15:0] b_cnt;

    telemetry_framer #(
        .NUM_CH(2), .DATA_W(16), .SAMPLE_DIV(64), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1)
    ) dut_a (
        .Clk(clk), .n_reset(a_rst_n), .i_enable(a_en), .i_data(a_din), .i_end(a_end),
        .i_uart_full(a_full), .o_data(a_dout), .o_wr(a_wr), .o_busy(a_busy),
        .o_overrun(a_ovr), .o_ended(a_ended), .o_frame_cnt(a_cnt)
    );

    telemetry_framer #(
        .NUM_CH(3), .DATA_W(8), .SAMPLE_DIV(8), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(0)
    ) dut_b (
        .Clk(clk), .n_reset(b_rst_n), .i_enable(b_en), .i_data(b_din), .i_end(b_end),
        .i_uart_full(b_full), .o_data(b_dout), .o_wr(b_wr), .o_busy(b_busy),
        .o_overrun(b_ovr), .o_ended(b_ended), .o_frame_cnt(b_cnt)
    );

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int a_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: every write strobe must match the next byte the stimulus queued.
    always @(negedge clk) begin
        if (a_wr === 1'b1) begin
            a_seen++;
            if (q_a.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL a_unexpected_wr: byte %0h written, none expected at t=%0t", a_dout, $time);
            end else begin
                check("a_byte", a_dout, q_a.pop_front());
            end
        end
        if (b_wr === 1'b1) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_unexpected_wr: byte %0h written, none expected at t=%0t", b_dout, $time);
            end else begin
                check("b_byte", b_dout, q_b.pop_front());
            end
        end
    end

    function automatic logic [7:0] model_chk(input logic [31:0] data, input logic [7:0] seq);
        logic [7:0] s;
        s = seq;
        for (int i = 0; i < 4; i++) s = s + data[i*8 +: 8];
        return 8'h00 - s;
    endfunction

    task automatic push_a(input logic [31:0] data, input logic [7:0] seq, input logic [7:0] chk);
        q_a.push_back(8'hA5);
        q_a.push_back(seq);
        for (int i = 0; i < 4; i++) q_a.push_back(data[i*8 +: 8]);
        q_a.push_back(chk);
    endtask

    task automatic push_b(input logic [23:0] data, input logic [7:0] seq);
        q_b.push_back(8'hA5);
        q_b.push_back(seq);
        for (int i = 0; i < 3; i++) q_b.push_back(data[i*8 +: 8]);
    endtask

    task automatic wait_a_seen(input int target, input int budget, input string name);
        int k = 0;
        while (a_seen < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, a_seen >= target, 1);
    endtask

    task automatic wait_a_cnt(input int target, input int budget, input string name);
        int k = 0;
        while (a_cnt != 16'(target) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, a_cnt, target);
    endtask

    task automatic wait_b_cnt(input int target, input int budget, input string name);
        int k = 0;
        while (b_cnt != 16'(target) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, b_cnt, target);
    endtask

    task automatic check_zero_a(input string name);
        check({name, "_data"}, a_dout, 0);
        check({name, "_wr"}, a_wr, 0);
        check({name, "_busy"}, a_busy, 0);
        check({name, "_ovr"}, a_ovr, 0);
        check({name, "_ended"}, a_ended, 0);
        check({name, "_cnt"}, a_cnt, 0);
    endtask

    // One frame on dut_a: wait for the SYNC write, then the other six bytes must
    // follow on consecutive cycles.
    task automatic run_frame_a();
        int base;
        base = a_seen;
        wait_a_seen(base + 1, 200, "a_first_byte");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("a_back_to_back", a_wr, 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[4];
        int base;
        vecs[0] = '{32'h1234_ABCD, 8'h00, 8'h42};
        vecs[1] = '{32'h0000_0000, 8'h01, 8'hFF};
        vecs[2] = '{32'hFFFF_FFFF, 8'h02, 8'h02};
        vecs[3] = '{32'h8001_7F80, 8'h03, 8'h7D};

        a_rst_n = 1'b0; a_en = 1'b0; a_end = 1'b0; a_full = 1'b0; a_din = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_end = 1'b0; b_full = 1'b0; b_din = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_a("a_reset");
        check("b_reset_wr", b_wr, 0);
        check("b_reset_cnt", b_cnt, 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero_a("a_idle");

        // Table-driven frames, back to back ticks with the divider running.
        a_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_din = vecs[i].data;
            push_a(vecs[i].data, vecs[i].seq, vecs[i].chk);
            run_frame_a();
            check("a_frame_cnt", a_cnt, i + 1);
            check("a_q_empty", q_a.size(), 0);
            check("a_busy_after", a_busy, 0);
        end

        // Backpressure for five cycles right after the SEQ byte.
        a_din = 32'hDEAD_BEEF;
        push_a(a_din, 8'h04, model_chk(32'hDEAD_BEEF, 8'h04));
        base = a_seen;
        wait_a_seen(base + 2, 200, "a_bp_seq");
        a_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("a_bp_no_wr", a_wr, 0);
            check("a_bp_hold", a_dout, 8'hEF);
            check("a_bp_busy", a_busy, 1);
        end
        @(posedge clk); #1;
        a_full = 1'b0;
        wait_a_cnt(5, 50, "a_bp_done");
        check("a_bp_q_empty", q_a.size(), 0);

        // End frame, then silence while i_end stays high.
        a_end = 1'b1;
        push_a(32'hFFFF_FFFF, 8'h05, model_chk(32'hFFFF_FFFF, 8'h05));
        wait_a_cnt(6, 200, "a_end_frame");
        check("a_ended_set", a_ended, 1);
        repeat (3 * 64 + 8) @(posedge clk);
        #1;
        check("a_end_no_frames", a_cnt, 6);
        check("a_ended_held", a_ended, 1);
        check("a_end_q_empty", q_a.size(), 0);
        a_end = 1'b0;
        a_din = 32'h0F1E_2D3C;
        @(posedge clk); #1;
        check("a_ended_clear", a_ended, 0);
        push_a(a_din, 8'h06, model_chk(32'h0F1E_2D3C, 8'h06));
        wait_a_cnt(7, 200, "a_resume");
        check("a_resume_q_empty", q_a.size(), 0);

        // Reset asserted while the fourth byte is on the bus.
        a_din = 32'h5566_7788;
        q_a.push_back(8'hA5);
        q_a.push_back(8'h07);
        q_a.push_back(8'h88);
        base = a_seen;
        wait_a_seen(base + 3, 200, "a_rst_third");
        #1;
        check("a_rst_pre_wr", a_wr, 1);
        check("a_rst_pre_data", a_dout, 8'h77);
        a_rst_n = 1'b0;
        #1;
        check_zero_a("a_rst_async");
        @(posedge clk);
        @(posedge clk); #1;
        check_zero_a("a_rst_held");
        a_rst_n = 1'b1;
        check("a_rst_q_empty", q_a.size(), 0);
        push_a(a_din, 8'h00, model_chk(32'h5566_7788, 8'h00));
        wait_a_cnt(1, 200, "a_post_rst_frame");
        check("a_post_rst_q_empty", q_a.size(), 0);
        a_en = 1'b0;

        // Five-byte frames without checksum; 256 frames wrap SEQ back to 00.
        b_din = 24'h3C_5A01;
        for (int f = 0; f < 256; f++) push_b(b_din, 8'(f));
        b_en = 1'b1;
        wait_b_cnt(256, 256 * 8 + 64, "b_wrap");
        b_en = 1'b0;
        check("b_wrap_q_empty", q_b.size(), 0);
        check("b_wrap_busy", b_busy, 0);
        check("b_wrap_ovr", b_ovr, 0);

        // Overrun: FIFO full across two ticks; shadow must ignore later i_data.
        push_b(24'hC0_FFEE, 8'h00);
        b_din  = 24'hC0_FFEE;
        b_full = 1'b1;
        b_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 12) b_din = 24'h12_3456;
        end
        check("b_ovr_set", b_ovr, 1);
        check("b_ovr_busy", b_busy, 1);
        check("b_ovr_no_wr", b_wr, 0);
        check("b_ovr_cnt_hold", b_cnt, 256);
        b_en   = 1'b0;
        b_full = 1'b0;
        wait_b_cnt(257, 30, "b_ovr_frame");
        repeat (40) @(posedge clk);
        #1;
        check("b_ovr_single", b_cnt, 257);
        check("b_ovr_q_empty", q_b.size(), 0);
        check("b_ovr_sticky", b_ovr, 1);
        check("b_ended_idle", b_ended, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
